// File: rtl/nibble_serial_sub32_if.sv
// Start/done handshake and result bus for the nibble-serial 32-bit subtractor.
// The slave side (the subtractor) also exposes its FSM state for checkers.
interface nibble_serial_sub32_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [31:0] diff;
  logic        bout;
  logic        zero;
  logic        ovf;
  logic [3:0]  dbg_state;

  // start is sampled only while busy=0; done is a one-cycle pulse and the
  // result fields are valid from that cycle until the next completion.
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero, ovf, dbg_state
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero, ovf, dbg_state
  );
endinterface

// File: rtl/nibble_serial_sub32.sv
// 32-bit subtractor diff = a - b - bin computed one nibble per clock through
// a single 4-bit datapath, LSB nibble first, with a registered borrow.
module nibble_serial_sub32 (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_sub32_if.slave  bus
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  logic [2:0]  r_k;
  logic        r_borrow;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_acc;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_diff;
  logic        r_bout;
  logic        r_zero;
  logic        r_ovf;

  logic [4:0]  w_idx;
  logic [3:0]  w_a_nib;
  logic [3:0]  w_b_nib;
  logic [4:0]  w_sum;
  logic [31:0] w_res;

  assign w_idx   = {r_k, 2'b00};
  assign w_a_nib = r_a[w_idx +: 4];
  assign w_b_nib = r_b[w_idx +: 4];
  // a - b - borrow as a + ~b + ~borrow; carry out is the inverted borrow
  assign w_sum   = {1'b0, w_a_nib} + {1'b0, ~w_b_nib} + {4'b0000, ~r_borrow};

  always_comb begin
    w_res = r_acc;
    w_res[w_idx +: 4] = w_sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_k      <= 3'd0;
      r_borrow <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_acc    <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= 32'd0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.bin;
            r_k      <= 3'd0;
            r_acc    <= 32'd0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_res;
          r_borrow <= ~w_sum[4];
          r_k      <= r_k + 3'd1;
          // Results reach the outputs only on the last slice
          if (r_k == 3'd7) begin
            r_diff  <= w_res;
            r_bout  <= ~w_sum[4];
            r_zero  <= ~|w_res;
            r_ovf   <= (r_a[31] != r_b[31]) && (w_res[31] != r_a[31]);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.zero      = r_zero;
  assign bus.ovf       = r_ovf;
  assign bus.dbg_state = {(r_state == S_RUN), r_k};

endmodule
